// File: rtl/kd_ctrl_pkg.sv
// Shared types and default sizes for the kd-tree query sequencer.
package kd_ctrl_pkg;

    localparam int unsigned KD_INTERNAL_WIDTH = 22;
    localparam int unsigned KD_PATCH_WIDTH    = 55;
    localparam int unsigned KD_ADDRESS_WIDTH  = 8;
    localparam int unsigned KD_NUM_LOAD_WORDS = 128;
    localparam int unsigned KD_TREE_LATENCY   = 9;
    localparam int unsigned KD_OUT_DEPTH      = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_QUERY = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Rides alongside a patch through the tree so its result can be captured.
    typedef struct packed {
        logic valid;
        logic last;
    } token_t;

endpackage

// File: rtl/kd_leaf_fifo.sv
// Synchronous result FIFO; count is registered so freed space shows up a cycle later.
module kd_leaf_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/kd_tree_query_ctrl.sv
// Loads node words into internal_node_tree, then streams query patches through it
// with enough output credit that the fixed-latency tree never has to stall.
module kd_tree_query_ctrl
    import kd_ctrl_pkg::*;
#(
    parameter int unsigned INTERNAL_WIDTH = KD_INTERNAL_WIDTH,
    parameter int unsigned PATCH_WIDTH    = KD_PATCH_WIDTH,
    parameter int unsigned ADDRESS_WIDTH  = KD_ADDRESS_WIDTH,
    parameter int unsigned NUM_LOAD_WORDS = KD_NUM_LOAD_WORDS,
    parameter int unsigned TREE_LATENCY   = KD_TREE_LATENCY,
    parameter int unsigned OUT_DEPTH      = KD_OUT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [INTERNAL_WIDTH-1:0] agg_data,
    input  logic                      agg_valid,
    output logic                      agg_ready,
    output logic                      tree_fsm_enable,
    output logic                      tree_sender_enable,
    output logic [INTERNAL_WIDTH-1:0] tree_sender_data,
    output logic [PATCH_WIDTH-1:0]    tree_patch_in,
    input  logic [ADDRESS_WIDTH-1:0]  tree_leaf_index,
    input  logic [PATCH_WIDTH-1:0]    patch_data,
    input  logic                      patch_valid,
    input  logic                      patch_last,
    output logic                      patch_ready,
    output logic [ADDRESS_WIDTH-1:0]  leaf_index,
    output logic                      leaf_valid,
    output logic                      leaf_last,
    input  logic                      leaf_ready,
    output logic                      load_done,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned WCW = $clog2(NUM_LOAD_WORDS + 1);
    localparam int unsigned CW  = $clog2(OUT_DEPTH + 1);
    localparam int unsigned SW  = CW + 1;

    state_t                   state_q;
    state_t                   state_d;
    logic [WCW-1:0]           word_cnt_q;
    logic [CW-1:0]            inflight_q;
    logic [CW-1:0]            fifo_count;
    logic [SW-1:0]            credit_sum;
    token_t                   tok_in_q;
    token_t                   sr_q [TREE_LATENCY];
    logic                     agg_acc;
    logic                     patch_acc;
    logic                     credit_ok;
    logic                     last_word;
    logic                     push;
    logic                     pop;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [ADDRESS_WIDTH:0]   fifo_head;

    assign busy               = (state_q != ST_IDLE);
    assign tree_fsm_enable    = busy;
    assign agg_ready          = (state_q == ST_LOAD);
    assign agg_acc            = agg_valid & agg_ready;
    assign tree_sender_enable = agg_acc;
    assign tree_sender_data   = agg_ready ? agg_data : '0;
    assign last_word          = (word_cnt_q == WCW'(NUM_LOAD_WORDS - 1));

    // Every accepted patch owns a slot until its result is popped.
    assign credit_sum  = SW'(inflight_q) + SW'(fifo_count);
    assign credit_ok   = (credit_sum < SW'(OUT_DEPTH));
    assign patch_ready = (state_q == ST_QUERY) & credit_ok;
    assign patch_acc   = patch_valid & patch_ready;

    assign push       = sr_q[TREE_LATENCY-1].valid;
    assign leaf_valid = ~fifo_empty;
    assign pop        = leaf_valid & leaf_ready;
    assign leaf_index = leaf_valid ? fifo_head[ADDRESS_WIDTH-1:0] : '0;
    assign leaf_last  = leaf_valid & fifo_head[ADDRESS_WIDTH];
    assign done       = pop & leaf_last & (state_q == ST_DRAIN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (agg_acc && last_word) state_d = ST_QUERY;
            ST_QUERY: if (patch_acc && patch_last) state_d = ST_DRAIN;
            ST_DRAIN: if (done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // tok_in_q lines up with tree_patch_in; sr_q then tracks the tree's own pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q    <= '0;
            inflight_q    <= '0;
            load_done     <= 1'b0;
            tree_patch_in <= '0;
            tok_in_q      <= '0;
            for (int i = 0; i < int'(TREE_LATENCY); i++) sr_q[i] <= '0;
        end else begin
            if (state_q == ST_IDLE && start) word_cnt_q <= '0;
            else if (agg_acc)                word_cnt_q <= word_cnt_q + WCW'(1);
            load_done <= (state_d == ST_QUERY) || (state_d == ST_DRAIN);
            if (patch_acc) tree_patch_in <= patch_data;
            tok_in_q   <= '{valid: patch_acc, last: patch_acc & patch_last};
            sr_q[0]    <= tok_in_q;
            for (int i = 1; i < int'(TREE_LATENCY); i++) sr_q[i] <= sr_q[i-1];
            inflight_q <= inflight_q + CW'(patch_acc) - CW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push && fifo_full))
            else $fatal(1, "kd_tree_query_ctrl: result push into full leaf FIFO");
    end

    kd_leaf_fifo #(
        .WIDTH (ADDRESS_WIDTH + 1),
        .DEPTH (OUT_DEPTH)
    ) u_leaf_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({sr_q[TREE_LATENCY-1].last, tree_leaf_index}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_kd_tree_query_ctrl.sv
// Bench for kd_tree_query_ctrl: a fixed-latency tree stand-in, a queue-based
// reference of the session/credit rules, and directed plus random sessions.
module tb_kd_tree_query_ctrl;

    localparam int IW = 22;
    localparam int PW = 55;
    localparam int AW = 8;
    localparam int NW = 128;
    localparam int L  = 9;
    localparam int D  = 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_QUERY = 2;
    localparam int PH_DRAIN = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] agg_data;
    logic          agg_valid;
    logic          agg_ready;
    logic          tree_fsm_enable;
    logic          tree_sender_enable;
    logic [IW-1:0] tree_sender_data;
    logic [PW-1:0] tree_patch_in;
    logic [AW-1:0] tree_leaf_index;
    logic [PW-1:0] patch_data;
    logic          patch_valid;
    logic          patch_last;
    logic          patch_ready;
    logic [AW-1:0] leaf_index;
    logic          leaf_valid;
    logic          leaf_last;
    logic          leaf_ready;
    logic          load_done;
    logic          busy;
    logic          done;

    kd_tree_query_ctrl #(
        .INTERNAL_WIDTH (IW),
        .PATCH_WIDTH    (PW),
        .ADDRESS_WIDTH  (AW),
        .NUM_LOAD_WORDS (NW),
        .TREE_LATENCY   (L),
        .OUT_DEPTH      (D)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .agg_data           (agg_data),
        .agg_valid          (agg_valid),
        .agg_ready          (agg_ready),
        .tree_fsm_enable    (tree_fsm_enable),
        .tree_sender_enable (tree_sender_enable),
        .tree_sender_data   (tree_sender_data),
        .tree_patch_in      (tree_patch_in),
        .tree_leaf_index    (tree_leaf_index),
        .patch_data         (patch_data),
        .patch_valid        (patch_valid),
        .patch_last         (patch_last),
        .patch_ready        (patch_ready),
        .leaf_index         (leaf_index),
        .leaf_valid         (leaf_valid),
        .leaf_last          (leaf_last),
        .leaf_ready         (leaf_ready),
        .load_done          (load_done),
        .busy               (busy),
        .done               (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] tree_fn(input logic [PW-1:0] p);
        return p[7:0] ^ p[15:8];
    endfunction

    // Tree stand-in: result for whatever sat on tree_patch_in L cycles earlier.
    logic [AW-1:0] tpipe [L];
    always @(posedge clk) begin
        tpipe[0] <= tree_fn(tree_patch_in);
        for (int i = 1; i < L; i++) tpipe[i] <= tpipe[i-1];
    end
    assign tree_leaf_index = tpipe[L-1];

    typedef struct {
        logic [AW-1:0] idx;
        logic          last;
        int            rdy;
    } res_t;

    typedef struct {
        logic [PW-1:0] patch;
        logic [AW-1:0] exp_idx;
    } sq_vec_t;

    res_t q[$];
    int   m_st, m_words, m_out, edge_n;
    int   n_chk, n_err;

    logic          s_agg_ready, s_tse, s_patch_ready, s_pv, s_lr;
    logic          s_leaf_valid, s_leaf_last, s_done, s_busy;
    logic [AW-1:0] s_leaf_index;
    int            s_edge;

    task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        agg_valid   = 1'b0;
        agg_data    = '0;
        patch_valid = 1'b0;
        patch_data  = '0;
        patch_last  = 1'b0;
        leaf_ready  = 1'b0;
    endtask

    // One cycle: compare against the reference, advance it, cross the edge.
    task automatic tick();
        logic          e_lv, e_ll, e_pr, e_done, acc, pp;
        logic [AW-1:0] e_li;
        #1;
        e_lv   = (q.size() > 0) && (q[0].rdy <= edge_n);
        e_li   = e_lv ? q[0].idx : '0;
        e_ll   = e_lv && q[0].last;
        e_pr   = (m_st == PH_QUERY) && (m_out < D);
        e_done = e_lv && leaf_ready && e_ll;
        ck("busy", 64'(busy), 64'(m_st != PH_IDLE));
        ck("tree_fsm_enable", 64'(tree_fsm_enable), 64'(m_st != PH_IDLE));
        ck("agg_ready", 64'(agg_ready), 64'(m_st == PH_LOAD));
        ck("tree_sender_enable", 64'(tree_sender_enable), 64'((m_st == PH_LOAD) && agg_valid));
        if ((m_st == PH_LOAD) && agg_valid)
            ck("tree_sender_data", 64'(tree_sender_data), 64'(agg_data));
        ck("patch_ready", 64'(patch_ready), 64'(e_pr));
        ck("leaf_valid", 64'(leaf_valid), 64'(e_lv));
        if (e_lv) begin
            ck("leaf_index", 64'(leaf_index), 64'(e_li));
            ck("leaf_last", 64'(leaf_last), 64'(e_ll));
        end
        ck("load_done", 64'(load_done), 64'((m_st == PH_QUERY) || (m_st == PH_DRAIN)));
        ck("done", 64'(done), 64'(e_done));
        s_agg_ready   = agg_ready;
        s_tse         = tree_sender_enable;
        s_patch_ready = patch_ready;
        s_pv          = patch_valid;
        s_lr          = leaf_ready;
        s_leaf_valid  = leaf_valid;
        s_leaf_index  = leaf_index;
        s_leaf_last   = leaf_last;
        s_done        = done;
        s_busy        = busy;
        s_edge        = edge_n;
        acc = e_pr && patch_valid;
        pp  = e_lv && leaf_ready;
        case (m_st)
            PH_IDLE: if (start) begin m_st = PH_LOAD; m_words = 0; end
            PH_LOAD: if (agg_valid) begin
                m_words++;
                if (m_words == NW) m_st = PH_QUERY;
            end
            PH_QUERY: if (acc) begin
                q.push_back('{idx: tree_fn(patch_data), last: patch_last, rdy: edge_n + L + 2});
                m_out++;
                if (patch_last) m_st = PH_DRAIN;
            end
            default: ;
        endcase
        if (pp) begin
            if (q[0].last) m_st = PH_IDLE;
            void'(q.pop_front());
            m_out--;
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic do_load(input bit start_noise);
        int sends, guard;
        start = 1'b1;
        tick();
        start = 1'b0;
        sends = 0;
        guard = 0;
        while (m_st == PH_LOAD && guard < 2000) begin
            agg_valid = ($urandom_range(99) < 70);
            agg_data  = IW'($urandom());
            start     = start_noise && ($urandom_range(99) < 10);
            tick();
            if (s_tse) sends++;
            guard++;
        end
        start = 1'b0;
        ck("load_word_count", 64'(sends), 64'(NW));
        agg_valid = 1'b1;
        agg_data  = '1;
        tick();
        ck("word129_agg_ready", 64'(s_agg_ready), 64'(0));
        ck("word129_enable", 64'(s_tse), 64'(0));
        agg_valid = 1'b0;
    endtask

    task automatic run_query(input int n, input int pv_pct, input int lr_pct, input int hold,
                             input bit start_noise, output int acc_hold, output int stall_hold,
                             output int stalls, output int gaps, output int pops);
        logic [PW-1:0] pd [$];
        int  idx, cyc;
        bit  seen;
        for (int i = 0; i < n; i++) pd.push_back(PW'({$urandom(), $urandom()}));
        idx = 0; cyc = 0; seen = 0;
        acc_hold = 0; stall_hold = 0; stalls = 0; gaps = 0; pops = 0;
        while (m_st != PH_IDLE && cyc < 20000) begin
            patch_valid = (idx < n) && ($urandom_range(99) < pv_pct);
            patch_data  = (idx < n) ? pd[idx] : '0;
            patch_last  = (idx == n - 1);
            leaf_ready  = (cyc >= hold) && ($urandom_range(99) < lr_pct);
            start       = start_noise && ($urandom_range(99) < 5);
            tick();
            if (s_pv && s_patch_ready) begin
                idx++;
                if (cyc < hold) acc_hold++;
            end
            if (s_pv && !s_patch_ready) begin
                stalls++;
                if (cyc < hold) stall_hold++;
            end
            if (s_leaf_valid) seen = 1;
            else if (seen && pops < n) gaps++;
            if (s_leaf_valid && s_lr) pops++;
            cyc++;
        end
        idle_inputs();
        ck("query_result_count", 64'(pops), 64'(n));
    endtask

    task automatic single_query(input logic [PW-1:0] p, input logic [AW-1:0] exp);
        int e0, lat;
        do_load(0);
        leaf_ready  = 1'b1;
        patch_valid = 1'b1;
        patch_data  = p;
        patch_last  = 1'b1;
        tick();
        ck("sq_accept", 64'(s_patch_ready), 64'(1));
        e0 = edge_n;
        patch_valid = 1'b0;
        patch_last  = 1'b0;
        lat = -1;
        for (int g = 0; g < 40; g++) begin
            tick();
            if (s_leaf_valid) begin
                lat = s_edge - e0;
                break;
            end
        end
        ck("sq_latency", 64'(lat), 64'(L + 1));
        ck("sq_index", 64'(s_leaf_index), 64'(exp));
        ck("sq_last", 64'(s_leaf_last), 64'(1));
        ck("sq_done", 64'(s_done), 64'(1));
        leaf_ready = 1'b0;
        tick();
        ck("sq_busy_after", 64'(s_busy), 64'(0));
    endtask

    task automatic check_zero(input string tag);
        ck({tag, "_agg_ready"}, 64'(agg_ready), 64'(0));
        ck({tag, "_tree_fsm_enable"}, 64'(tree_fsm_enable), 64'(0));
        ck({tag, "_tree_sender_enable"}, 64'(tree_sender_enable), 64'(0));
        ck({tag, "_tree_sender_data"}, 64'(tree_sender_data), 64'(0));
        ck({tag, "_tree_patch_in"}, 64'(tree_patch_in), 64'(0));
        ck({tag, "_patch_ready"}, 64'(patch_ready), 64'(0));
        ck({tag, "_leaf_index"}, 64'(leaf_index), 64'(0));
        ck({tag, "_leaf_valid"}, 64'(leaf_valid), 64'(0));
        ck({tag, "_leaf_last"}, 64'(leaf_last), 64'(0));
        ck({tag, "_load_done"}, 64'(load_done), 64'(0));
        ck({tag, "_busy"}, 64'(busy), 64'(0));
        ck({tag, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time %0t reached without finishing", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        sq_vec_t tbl [5];
        int a_h, s_h, st, gp, pp, n_ready;

        tbl[0] = '{patch: 55'h2A,               exp_idx: 8'h2A};
        tbl[1] = '{patch: 55'h1234,             exp_idx: 8'h26};
        tbl[2] = '{patch: 55'hFF00,             exp_idx: 8'hFF};
        tbl[3] = '{patch: 55'hC381,             exp_idx: 8'h42};
        tbl[4] = '{patch: 55'h7F_FFFF_FFFF_FFFF, exp_idx: 8'h00};

        n_chk = 0; n_err = 0; edge_n = 0;
        m_st = PH_IDLE; m_words = 0; m_out = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) single_query(tbl[i].patch, tbl[i].exp_idx);

        // Backpressure, with start pulses thrown at the load phase.
        do_load(1);
        run_query(40, 100, 100, 40, 0, a_h, s_h, st, gp, pp);
        ck("bp_accepted_while_blocked", 64'(a_h), 64'(D));
        ck("bp_refused_while_blocked", 64'(s_h), 64'(40 - D));

        // Streaming, with start pulses thrown at the query phase.
        do_load(0);
        run_query(200, 100, 100, 0, 1, a_h, s_h, st, gp, pp);
        ck("stream_patch_stalls", 64'(st), 64'(0));
        ck("stream_leaf_gaps", 64'(gp), 64'(0));

        for (int r = 0; r < 3; r++) begin
            do_load(0);
            run_query(int'($urandom_range(60, 1)), int'($urandom_range(100, 30)),
                      int'($urandom_range(100, 20)), 0, 1, a_h, s_h, st, gp, pp);
        end

        // Abort mid-query: eight accepted, three of them already queued.
        do_load(0);
        for (int i = 0; i < 8; i++) begin
            patch_valid = 1'b1;
            patch_data  = PW'({$urandom(), $urandom()});
            patch_last  = 1'b0;
            tick();
        end
        patch_valid = 1'b0;
        for (int g = 0; g < 30; g++) begin
            n_ready = 0;
            foreach (q[k]) if (q[k].rdy <= edge_n) n_ready++;
            if (n_ready >= 3) break;
            tick();
        end
        ck("pre_abort_queued", 64'(n_ready), 64'(3));
        ck("pre_abort_leaf_valid", 64'(leaf_valid), 64'(1));
        agg_valid  = 1'b1;
        agg_data   = '1;
        leaf_ready = 1'b1;
        rst_n      = 1'b0;
        #1;
        check_zero("abort");
        m_st = PH_IDLE; m_out = 0; q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        tick();
        ck("post_abort_leaf_valid", 64'(s_leaf_valid), 64'(0));
        ck("post_abort_busy", 64'(s_busy), 64'(0));
        single_query(tbl[0].patch, tbl[0].exp_idx);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/kd_tree_query_ctrl.md
Name: kd_tree_query_ctrl

Overview:
Sequencer for internal_node_tree. Phase 1 streams NUM_LOAD_WORDS aggregated internal-node words from the aggregator into the tree. Phase 2 issues query patches into the fixed-latency tree pipeline and returns leaf indices in order through a credit-limited output FIFO. The tree pipeline therefore never has to stall. Sits between the aggregator/patch source and the downstream leaf-scan stage.

Parameters:
INTERNAL_WIDTH, 22, width of one aggregated node word (FETCH_WIDTH x DSIZE)
PATCH_WIDTH, 55, width of one query patch
ADDRESS_WIDTH, 8, width of leaf index
NUM_LOAD_WORDS, 128, node words accepted before the load phase completes
TREE_LATENCY, 9, cycles from tree patch_in to valid leaf_index (>=1)
OUT_DEPTH, 16, output FIFO entries; also the in-flight credit limit (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load+query session
agg_data  in  INTERNAL_WIDTH  node word from aggregator
agg_valid  in  1  aggregator word valid (receiver_enq)
agg_ready  out  1  to aggregator receiver_full_n
tree_fsm_enable  out  1  tree fsm_enable
tree_sender_enable  out  1  tree node-write strobe
tree_sender_data  out  INTERNAL_WIDTH  tree node word
tree_patch_in  out  PATCH_WIDTH  patch driven into tree
tree_leaf_index  in  ADDRESS_WIDTH  tree result
patch_data  in  PATCH_WIDTH  query patch
patch_valid  in  1  patch valid
patch_last  in  1  final patch of session
patch_ready  out  1  patch accepted when valid&ready
leaf_index  out  ADDRESS_WIDTH  result, FIFO head
leaf_valid  out  1  FIFO non-empty
leaf_last  out  1  result belongs to the last patch
leaf_ready  in  1  downstream pop
load_done  out  1  high from the end of load until the session ends
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the last result is popped

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters, shift register and FIFO cleared; all outputs 0; tree_patch_in=0.
- States: IDLE -> LOAD (start) -> QUERY (word NUM_LOAD_WORDS-1 accepted) -> DRAIN (patch_last accepted) -> IDLE (popped entry has leaf_last; done=1 that cycle).
- start is ignored outside IDLE.
- tree_fsm_enable=1 in every state except IDLE.
- LOAD:
  - agg_ready=1.
  - tree_sender_enable = agg_valid & agg_ready, combinational.
  - tree_sender_data = agg_data, passed through.
  - Word counter increments per accepted word; the final word transitions to QUERY on the next edge.
  - agg_ready=0 in all other states; extra aggregator words stall.
- QUERY:
  - credit_ok = (inflight + fifo_count) < OUT_DEPTH.
  - patch_ready = credit_ok.
  - On accept: tree_patch_in registered to patch_data; a token {1, patch_last} enters a TREE_LATENCY-stage shift register.
  - When no patch is accepted, tree_patch_in holds its value and a {0,0} token enters.
  - inflight = number of valid tokens in the shift register.
  - Accepting patch_last moves the state to DRAIN.
  - patch_ready=0 in LOAD, DRAIN and IDLE.
- Shift-register output valid: push {tree_leaf_index, last} into the FIFO the same edge.
  - Credit accounting guarantees the FIFO is never full at a push; a push to a full FIFO is a fatal assertion.
- FIFO:
  - Head is shown with leaf_valid, leaf_index and leaf_last.
  - Pop on leaf_valid & leaf_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pop-side capacity freed in cycle N is credited in cycle N+1 (count is registered).
- Latency, empty FIFO: patch accepted at edge E; leaf_valid rises at edge E+TREE_LATENCY+1.
- Throughput: one patch/cycle while leaf_ready=1.
- load_done: set on entry to QUERY; cleared on return to IDLE.
- Widths:
  - Word counter: clog2(NUM_LOAD_WORDS+1) bits.
  - inflight and fifo_count: clog2(OUT_DEPTH+1) bits.
  - All counters saturate-free by construction; no wrap occurs.
- Mid-session rst_n assertion aborts everything; the tree must be reloaded after reset.

Decomposition:
- Package kd_ctrl_pkg holds:
  - state enum (IDLE, LOAD, QUERY, DRAIN);
  - the token struct {valid, last};
  - default-width localparams.
- One sub-module: kd_leaf_fifo, a synchronous FIFO with OUT_DEPTH entries, width ADDRESS_WIDTH+1, ports push/pop/count/empty/full.
- The latency shift register stays inline.

Test Plan:
- Load: start, then 128 words with random agg_valid gaps -> exactly 128 tree_sender_enable pulses carrying the words in order; load_done rises after word 127; the 129th word sees agg_ready=0.
- Single query: with the tree model returning index 0x2A, one patch with patch_last accepted at edge E -> leaf_valid at E+10 with leaf_index=0x2A and leaf_last=1; done pulses when it is popped; busy=0 the next cycle.
- Backpressure: leaf_ready=0 while 40 patches are offered -> exactly 16 accepted, patch_ready=0 afterwards. Then leaf_ready=1 -> all 40 results in order, no overflow assertion.
- Streaming: leaf_ready=1 with 200 back-to-back patches -> patch_ready stays 1 and leaf_valid is continuous after the first TREE_LATENCY+1 cycles.
- Reset mid-QUERY: rst_n low with 5 in flight and 3 queued -> all outputs 0 immediately; after release, state IDLE and leaf_valid=0; a fresh start works.
- start pulsed during LOAD or QUERY -> no effect on the word counter or the state.
